// File: rtl/alu_iter.sv
// Execute-stage ALU, iterative shifter; optional flush input under ALU_ITER_FLUSH_EN.
// Latency: 1 cycle for logic/arith/compare, 1 + ceil(shamt/SHIFT_STEP) for shifts.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module alu_iter #(
   parameter int DATA_WIDTH = 32,
   parameter int SHIFT_STEP = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3:0]            Operation,
   input  logic [DATA_WIDTH-1:0] SrcA,
   input  logic [DATA_WIDTH-1:0] SrcB,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] ALUResult,
   output logic                  Zero
`ifdef ALU_ITER_FLUSH_EN
   ,
   input  logic                  flush
`endif
);

   localparam int SW = $clog2(DATA_WIDTH);
   localparam logic [SW:0] STEP = (SW+1)'(SHIFT_STEP);

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SLL = 4'b0100;
   localparam logic [3:0] OP_SRL = 4'b0101;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SRA = 4'b0111;
   localparam logic [3:0] OP_EQ  = 4'b1000;
   localparam logic [3:0] OP_SLT = 4'b1100;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   typedef enum logic [1:0] {SK_SLL, SK_SRL, SK_SRA} shift_kind_t;

   state_t                state;
   shift_kind_t           kind;
   shift_kind_t           kind_in;
   logic [SW-1:0]         cnt;
   logic [SW-1:0]         cnt_next;
   logic [SW:0]           step_d;
   logic [SW-1:0]         shamt;
   logic                  is_shift;
   logic                  flush_i;
   logic [DATA_WIDTH-1:0] result;
   logic [DATA_WIDTH-1:0] alu_res;
   logic [DATA_WIDTH-1:0] shift_res;

`ifdef ALU_ITER_FLUSH_EN
   assign flush_i = flush;
`else
   assign flush_i = 1'b0;
`endif

   assign in_ready  = (state == IDLE) && !reset;
   assign out_valid = (state == DONE);
   assign ALUResult = result;
   assign Zero      = (result == '0);
   assign shamt     = SrcB[SW-1:0];

   always_comb begin
      alu_res = '0;
      case (Operation)
         OP_AND:  alu_res = SrcA & SrcB;
         OP_OR:   alu_res = SrcA | SrcB;
         OP_ADD:  alu_res = SrcA + SrcB;
         OP_SUB:  alu_res = SrcA - SrcB;
         OP_EQ:   alu_res = {{(DATA_WIDTH-1){1'b0}}, (SrcA == SrcB)};
         OP_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      is_shift = 1'b1;
      kind_in  = SK_SLL;
      case (Operation)
         OP_SLL:  kind_in = SK_SLL;
         OP_SRL:  kind_in = SK_SRL;
         OP_SRA:  kind_in = SK_SRA;
         default: is_shift = 1'b0;
      endcase
   end

   // One iteration moves at most STEP bits; the final one may be shorter.
   always_comb begin
      if ({1'b0, cnt} < STEP) step_d = {1'b0, cnt};
      else                    step_d = STEP;
      cnt_next = cnt - step_d[SW-1:0];
      case (kind)
         SK_SRL:  shift_res = result >> step_d;
         SK_SRA:  shift_res = $unsigned($signed(result) >>> step_d);
         default: shift_res = result << step_d;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         result <= '0;
         cnt    <= '0;
         kind   <= SK_SLL;
      end else if (flush_i) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  if (is_shift) begin
                     result <= SrcA;
                     cnt    <= shamt;
                     kind   <= kind_in;
                     state  <= (shamt == '0) ? DONE : SHIFT;
                  end else begin
                     result <= alu_res;
                     state  <= DONE;
                  end
               end
            end
            SHIFT: begin
               result <= shift_res;
               cnt    <= cnt_next;
               if (cnt_next == '0) state <= DONE;
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_iter.sv
// Directed bench for alu_iter: dut1 uses SHIFT_STEP=1, dut4 uses SHIFT_STEP=4.
module tb_alu_iter;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]       rst;
   logic [1:0]       in_valid;
   logic [1:0]       out_ready;
   logic [1:0][3:0]  op;
   logic [1:0][31:0] a;
   logic [1:0][31:0] b;
   wire  [1:0]       in_ready;
   wire  [1:0]       out_valid;
   wire  [1:0]       zero;
   wire  [1:0][31:0] res;
`ifdef ALU_ITER_FLUSH_EN
   logic [1:0]       flush;
`endif

   int total = 0;
   int npass = 0;
   int lat;
   int bad;

   alu_iter #(.DATA_WIDTH(32), .SHIFT_STEP(1)) dut1 (
      .clk(clk), .reset(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .Operation(op[0]), .SrcA(a[0]), .SrcB(b[0]), .out_valid(out_valid[0]),
      .out_ready(out_ready[0]), .ALUResult(res[0]), .Zero(zero[0])
`ifdef ALU_ITER_FLUSH_EN
      , .flush(flush[0])
`endif
   );

   alu_iter #(.DATA_WIDTH(32), .SHIFT_STEP(4)) dut4 (
      .clk(clk), .reset(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .Operation(op[1]), .SrcA(a[1]), .SrcB(b[1]), .out_valid(out_valid[1]),
      .out_ready(out_ready[1]), .ALUResult(res[1]), .Zero(zero[1])
`ifdef ALU_ITER_FLUSH_EN
      , .flush(flush[1])
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) npass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
   endtask

   // Present a request, wait for acceptance, scramble operands, then count cycles to out_valid.
   task automatic issue(input int s, input logic [3:0] o, input logic [31:0] x,
                        input logic [31:0] y, output int l);
      int w;
      @(negedge clk);
      op[s] = o; a[s] = x; b[s] = y; in_valid[s] = 1'b1;
      w = 0;
      while (in_ready[s] !== 1'b1 && w < 100) begin
         @(negedge clk);
         w++;
      end
      @(posedge clk);
      #1;
      in_valid[s] = 1'b0; op[s] = ~o; a[s] = ~x; b[s] = ~y;
      l = 1;
      @(negedge clk);
      while (out_valid[s] !== 1'b1 && l < 200) begin
         @(negedge clk);
         l++;
      end
   endtask

   initial begin
      rst = 2'b11; in_valid = 2'b00; out_ready = 2'b11;
      op = '0; a = '0; b = '0;
`ifdef ALU_ITER_FLUSH_EN
      flush = 2'b00;
`endif
      repeat (3) @(negedge clk);
      chk("rst_in_ready_low", {31'b0, in_ready[0]}, 32'd0);
      chk("rst_out_valid_low", {31'b0, out_valid[0]}, 32'd0);
      rst = 2'b00;
      @(negedge clk);
      chk("post_rst_in_ready", {31'b0, in_ready[0]}, 32'd1);
      chk("post_rst_result", res[0], 32'd0);
      chk("post_rst_zero", {31'b0, zero[0]}, 32'd1);
      chk("post_rst_in_ready4", {31'b0, in_ready[1]}, 32'd1);

      issue(0, 4'b0010, 32'd5, 32'd7, lat);
      chk("add_lat", lat, 32'd1);
      chk("add_res", res[0], 32'd12);
      chk("add_zero", {31'b0, zero[0]}, 32'd0);
      @(negedge clk);
      chk("add_in_ready_back", {31'b0, in_ready[0]}, 32'd1);
      chk("add_out_valid_drop", {31'b0, out_valid[0]}, 32'd0);
      chk("add_res_held", res[0], 32'd12);

      issue(0, 4'b0110, 32'd3, 32'd3, lat);
      chk("sub_eq_res", res[0], 32'd0);
      chk("sub_eq_zero", {31'b0, zero[0]}, 32'd1);
      issue(0, 4'b0110, 32'd3, 32'd5, lat);
      chk("sub_neg_res", res[0], 32'hFFFF_FFFE);
      issue(0, 4'b1100, 32'hFFFF_FFFF, 32'd1, lat);
      chk("slt_neg_lt", res[0], 32'd1);
      issue(0, 4'b1100, 32'd1, 32'hFFFF_FFFF, lat);
      chk("slt_pos_ge", res[0], 32'd0);
      issue(0, 4'b0000, 32'h0000_F0F0, 32'h0000_FF00, lat);
      chk("and_res", res[0], 32'h0000_F000);
      issue(0, 4'b1111, 32'd9, 32'd9, lat);
      chk("unused_1111_res", res[0], 32'd0);
      chk("unused_1111_lat", lat, 32'd1);
      issue(0, 4'b1000, 32'hA5, 32'hA5, lat);
      chk("eq_match", res[0], 32'd1);
      chk("eq_match_zero", {31'b0, zero[0]}, 32'd0);
      issue(0, 4'b1001, 32'hA5, 32'hA5, lat);
      chk("unused_1001_res", res[0], 32'd0);
      issue(0, 4'b1000, 32'hA5, 32'hA4, lat);
      chk("eq_mismatch", res[0], 32'd0);

      issue(0, 4'b0111, 32'h8000_0000, 32'd31, lat);
      chk("sra31_lat", lat, 32'd32);
      chk("sra31_res", res[0], 32'hFFFF_FFFF);
      issue(0, 4'b0101, 32'h8000_0000, 32'd31, lat);
      chk("srl31_lat", lat, 32'd32);
      chk("srl31_res", res[0], 32'd1);
      issue(0, 4'b0100, 32'd1, 32'd0, lat);
      chk("sll0_lat", lat, 32'd1);
      chk("sll0_res", res[0], 32'd1);
      issue(0, 4'b0100, 32'd3, 32'h25, lat);
      chk("sll_shamt_mask_lat", lat, 32'd6);
      chk("sll_shamt_mask_res", res[0], 32'h60);

      issue(1, 4'b0100, 32'd1, 32'd5, lat);
      chk("s4_sll5_lat", lat, 32'd3);
      chk("s4_sll5_res", res[1], 32'h20);
      issue(1, 4'b0111, 32'h8000_0000, 32'd31, lat);
      chk("s4_sra31_lat", lat, 32'd9);
      chk("s4_sra31_res", res[1], 32'hFFFF_FFFF);
      issue(1, 4'b0101, 32'hF000_0000, 32'd7, lat);
      chk("s4_srl7_lat", lat, 32'd3);
      chk("s4_srl7_res", res[1], 32'h01E0_0000);

      // Reset arrives while dut4 is still iterating a 20-bit shift.
      @(negedge clk);
      op[1] = 4'b0100; a[1] = 32'd1; b[1] = 32'd20; in_valid[1] = 1'b1;
      @(posedge clk);
      #1 in_valid[1] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst[1] = 1'b1;
      @(negedge clk);
      chk("midrst_out_valid", {31'b0, out_valid[1]}, 32'd0);
      chk("midrst_res", res[1], 32'd0);
      chk("midrst_in_ready", {31'b0, in_ready[1]}, 32'd0);
      rst[1] = 1'b0;
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (out_valid[1] !== 1'b0) bad++;
      end
      chk("midrst_no_stale_valid", bad, 32'd0);
      chk("midrst_idle", {31'b0, in_ready[1]}, 32'd1);

      out_ready[0] = 1'b0;
      issue(0, 4'b0001, 32'hF0, 32'h0F, lat);
      chk("bp_or_lat", lat, 32'd1);
      op[0] = 4'b0010; a[0] = 32'd1; b[0] = 32'd1; in_valid[0] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("bp_out_valid", {31'b0, out_valid[0]}, 32'd1);
         chk("bp_res", res[0], 32'hFF);
         chk("bp_in_ready", {31'b0, in_ready[0]}, 32'd0);
         @(negedge clk);
      end
      out_ready[0] = 1'b1;
      @(negedge clk);
      chk("bp_release_in_ready", {31'b0, in_ready[0]}, 32'd1);
      chk("bp_release_out_valid", {31'b0, out_valid[0]}, 32'd0);
      @(posedge clk);
      #1 in_valid[0] = 1'b0;
      @(negedge clk);
      chk("bp_next_valid", {31'b0, out_valid[0]}, 32'd1);
      chk("bp_next_res", res[0], 32'd2);

`ifdef ALU_ITER_FLUSH_EN
      @(negedge clk);
      op[0] = 4'b0101; a[0] = 32'hFFFF_FFFF; b[0] = 32'd20; in_valid[0] = 1'b1;
      @(posedge clk);
      #1 in_valid[0] = 1'b0;
      repeat (4) @(negedge clk);
      flush[0] = 1'b1;
      @(posedge clk);
      #1 flush[0] = 1'b0;
      @(negedge clk);
      chk("flush_shift_out_valid", {31'b0, out_valid[0]}, 32'd0);
      chk("flush_shift_in_ready", {31'b0, in_ready[0]}, 32'd1);
      chk("flush_shift_res_kept", res[0], 32'h1FFF_FFFF);
      bad = 0;
      repeat (25) begin
         @(negedge clk);
         if (out_valid[0] !== 1'b0) bad++;
      end
      chk("flush_shift_no_valid", bad, 32'd0);

      out_ready[0] = 1'b0;
      issue(0, 4'b0010, 32'd2, 32'd3, lat);
      chk("flush_done_res", res[0], 32'd5);
      flush[0] = 1'b1; out_ready[0] = 1'b1;
      @(posedge clk);
      #1 flush[0] = 1'b0;
      @(negedge clk);
      chk("flush_done_out_valid", {31'b0, out_valid[0]}, 32'd0);
      chk("flush_done_in_ready", {31'b0, in_ready[0]}, 32'd1);
      chk("flush_done_res_kept", res[0], 32'd5);
      bad = 0;
      repeat (5) begin
         @(negedge clk);
         if (out_valid[0] !== 1'b0) bad++;
      end
      chk("flush_done_no_second", bad, 32'd0);
`endif

      $display("%0d/%0d checks passed", npass, total);
      $finish;
   end
endmodule
